// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract with the carry chain cut into
// STAGES registered slices and a valid/ready handshake on both sides.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int C = WIDTH / STAGES;

  logic en;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    // RI: operand bits still to be added, SO: sum bits done after this slice
    localparam int RI = WIDTH - k * C;
    localparam int SO = (k + 1) * C;

    logic          xv;
    logic          xc;
    logic [RI-1:0] xa;
    logic [RI-1:0] xb;
    logic [C-1:0]  ns;
    logic          co;
    logic [SO-1:0] sn;
    logic          v_d;
    logic          v_q;
    logic          c_d;
    logic          c_q;
    logic [SO-1:0] s_d;
    logic [SO-1:0] s_q;

    if (k == 0) begin : g_in
      assign xv = in_valid;
      assign xc = sub | cin;
      assign xa = a;
      assign xb = sub ? ~b : b;
      assign sn = ns;
    end else begin : g_in
      assign xv = g_st[k-1].v_q;
      assign xc = g_st[k-1].c_q;
      assign xa = g_st[k-1].g_op.a_q;
      assign xb = g_st[k-1].g_op.b_q;
      assign sn = {ns, g_st[k-1].s_q};
    end

    always_comb begin : slice
      logic cy;
      cy = xc;
      ns = '0;
      for (int j = 0; j < C; j++) begin
        ns[j] = xa[j] ^ xb[j] ^ cy;
        cy    = (xa[j] & xb[j])
              | (xa[j] & cy)
              | (xb[j] & cy);
      end
      co = cy;
    end

    always_comb begin
      v_d = v_q;
      c_d = c_q;
      s_d = s_q;
      if (en) begin
        v_d = xv;
        c_d = co;
        s_d = sn;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else begin
        v_q <= v_d;
        c_q <= c_d;
        s_q <= s_d;
      end
    end

    if (k < STAGES - 1) begin : g_op
      localparam int RO = RI - C;

      logic [RO-1:0] a_d;
      logic [RO-1:0] a_q;
      logic [RO-1:0] b_d;
      logic [RO-1:0] b_q;

      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (en) begin
          a_d = xa[RI-1:C];
          b_d = xb[RI-1:C];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end else begin : g_last
      logic o_d;
      logic o_q;

      // signs of A and (possibly inverted) B agree but the sum sign differs
      always_comb begin
        o_d = o_q;
        if (en) begin
          o_d = (xa[C-1] == xb[C-1])
              & (ns[C-1] != xa[C-1]);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          o_q <= 1'b0;
        end else begin
          o_q <= o_d;
        end
      end
    end
  end

  assign out_valid = g_st[STAGES-1].v_q;
  assign sum       = g_st[STAGES-1].s_q;
  assign cout      = g_st[STAGES-1].c_q;
  assign ovf       = g_st[STAGES-1].g_last.o_q;

endmodule
